// File: rtl/cpu_test_pkg.sv
// Shared types and defaults for the CPU self-check sequencer.
package cpu_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESET    = 3'd1,
    S_RUN      = 3'd2,
    S_CHK_REQ  = 3'd3,
    S_CHK_WAIT = 3'd4,
    S_DONE     = 3'd5
  } seq_state_t;

  localparam logic CHK_REG = 1'b0;
  localparam logic CHK_MEM = 1'b1;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/cpu_test_sequencer_counter.sv
// Loadable down-counter with zero flag; shared by the reset, run and probe-timeout phases.
module cycle_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_test_sequencer.sv
// Self-check sequencer: reset the CPU, let it run, then probe and compare a table of locations.
// state      | meaning
// S_IDLE     | waiting for start, CPU held in reset
// S_RESET    | CPU reset asserted for RESET_CYCLES
// S_RUN      | CPU running until RUN_CYCLES elapse or halt
// S_CHK_REQ  | issue probe for entry idx, or skip it if disabled
// S_CHK_WAIT | wait for probe response or timeout
// S_DONE     | result valid, CPU parked in reset
module cpu_test_sequencer
  import cpu_test_pkg::*;
#(
  parameter int XLEN          = DEF_XLEN,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int NUM_CHECKS    = 8,
  parameter int RESET_CYCLES  = 2,
  parameter int RUN_CYCLES    = 15,
  parameter int PROBE_TIMEOUT = 8,
  localparam int FC_W  = $clog2(NUM_CHECKS + 1),
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cpu_halt,
  input  logic [NUM_CHECKS-1:0]        chk_en,
  input  logic [NUM_CHECKS-1:0]        chk_is_mem,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*XLEN-1:0]   chk_exp,
  output logic                         cpu_rst,
  output logic                         probe_req,
  output logic                         probe_is_mem,
  output logic [ADDR_W-1:0]            probe_addr,
  input  logic                         probe_valid,
  input  logic [XLEN-1:0]              probe_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [FC_W-1:0]              fail_count,
  output logic [IDX_W-1:0]             first_fail_idx,
  output logic [15:0]                  run_cycles_used
);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             entry_en, last_idx, probe_active, resolve, mismatch;
  logic [XLEN-1:0]  exp_sel;

  assign entry_en     = chk_en[idx];
  assign last_idx     = (idx == IDX_W'(NUM_CHECKS - 1));
  assign exp_sel      = chk_exp[idx*XLEN +: XLEN];
  assign probe_active = (state == S_CHK_REQ) || (state == S_CHK_WAIT);
  // A response wins over a timeout landing in the same cycle.
  assign resolve      = (state == S_CHK_WAIT) && (probe_valid || cnt_zero);
  assign mismatch     = !probe_valid || (probe_data != exp_sel);

  assign cpu_rst      = !((state == S_RUN) || probe_active);
  assign busy         = !((state == S_IDLE) || (state == S_DONE));
  assign probe_req    = (state == S_CHK_REQ) && entry_en;
  assign probe_is_mem = probe_active && chk_is_mem[idx];
  assign probe_addr   = probe_active ? chk_addr[idx*ADDR_W +: ADDR_W] : '0;

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      S_IDLE, S_DONE: begin
        cnt_load = start;
        cnt_val  = CNT_W'(RESET_CYCLES - 1);
      end
      S_RESET: begin
        cnt_load = cnt_zero;
        cnt_dec  = !cnt_zero;
        cnt_val  = CNT_W'(RUN_CYCLES - 1);
      end
      S_RUN:      cnt_dec = 1'b1;
      S_CHK_REQ: begin
        cnt_load = entry_en;
        cnt_val  = CNT_W'(PROBE_TIMEOUT - 1);
      end
      S_CHK_WAIT: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  cycle_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      run_cycles_used <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_RESET;
            idx             <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            run_cycles_used <= '0;
          end
        end
        S_RESET: begin
          if (cnt_zero) state <= S_RUN;
        end
        S_RUN: begin
          if (run_cycles_used != 16'hFFFF) run_cycles_used <= run_cycles_used + 16'd1;
          if (cpu_halt || cnt_zero) begin
            state <= S_CHK_REQ;
            idx   <= '0;
          end
        end
        S_CHK_REQ: begin
          if (entry_en) begin
            state <= S_CHK_WAIT;
          end else if (last_idx) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (fail_count == '0);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_CHK_WAIT: begin
          if (resolve) begin
            if (mismatch) begin
              fail_count <= fail_count + FC_W'(1);
              if (fail_count == '0) first_fail_idx <= idx;
            end
            if (last_idx) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (fail_count == '0) && !mismatch;
            end else begin
              state <= S_CHK_REQ;
              idx   <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Randomized self-check bench: a cycle-schedule model of the sequencer plus a probe responder.
module tb_cpu_test_sequencer;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 10;
  localparam int N      = 8;
  localparam int RC     = 2;
  localparam int RUNC   = 15;
  localparam int PT     = 8;
  localparam int FC_W   = $clog2(N + 1);
  localparam int IDX_W  = $clog2(N);

  logic                  clk, rst, start, cpu_halt;
  logic [N-1:0]          chk_en, chk_is_mem;
  logic [N*ADDR_W-1:0]   chk_addr;
  logic [N*XLEN-1:0]     chk_exp;
  logic                  cpu_rst, probe_req, probe_is_mem, probe_valid;
  logic [ADDR_W-1:0]     probe_addr;
  logic [XLEN-1:0]       probe_data;
  logic                  busy, done, pass;
  logic [FC_W-1:0]       fail_count;
  logic [IDX_W-1:0]      first_fail_idx;
  logic [15:0]           run_cycles_used;

  int n_tests = 0;
  int n_fail  = 0;

  bit                en_a[N];
  bit                mem_a[N];
  logic [ADDR_W-1:0] addr_a[N];
  logic [XLEN-1:0]   exp_a[N];
  int                lat_a[N];   // 0 = responder stays silent
  bit                garble[N];  // also drive a bogus response in the request cycle
  int                halt_at;    // RUN cycle (1-based) in which halt is raised, 0 = never
  logic [XLEN-1:0]   rf[32];
  logic [XLEN-1:0]   dmem[1024];

  cpu_test_sequencer #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_CHECKS(N),
    .RESET_CYCLES(RC), .RUN_CYCLES(RUNC), .PROBE_TIMEOUT(PT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cpu_halt(cpu_halt),
    .chk_en(chk_en), .chk_is_mem(chk_is_mem), .chk_addr(chk_addr), .chk_exp(chk_exp),
    .cpu_rst(cpu_rst), .probe_req(probe_req), .probe_is_mem(probe_is_mem),
    .probe_addr(probe_addr), .probe_valid(probe_valid), .probe_data(probe_data),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .run_cycles_used(run_cycles_used)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [XLEN-1:0] peek(input bit m, input logic [ADDR_W-1:0] a);
    return m ? dmem[a] : rf[a[4:0]];
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      en_a[i] = 0; mem_a[i] = 0; addr_a[i] = '0; exp_a[i] = '0; lat_a[i] = 1; garble[i] = 0;
    end
    halt_at = 0;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < N; i++) begin
      chk_en[i]                     = en_a[i];
      chk_is_mem[i]                 = mem_a[i];
      chk_addr[i*ADDR_W +: ADDR_W]  = addr_a[i];
      chk_exp[i*XLEN +: XLEN]       = exp_a[i];
    end
  endtask

  task automatic set_baseline();
    clear_cfg();
    en_a[0] = 1; mem_a[0] = 0; addr_a[0] = 10'd1; exp_a[0] = 32'h12345000; lat_a[0] = 1;
    en_a[1] = 1; mem_a[1] = 0; addr_a[1] = 10'd2; exp_a[1] = 32'h12345001; lat_a[1] = 2;
    en_a[2] = 1; mem_a[2] = 1; addr_a[2] = 10'd0; exp_a[2] = 32'h12345001; lat_a[2] = 3;
  endtask

  // Expected schedule: each disabled entry costs one cycle, each enabled one
  // costs the request cycle plus its response latency (PT when silent).
  task automatic run_seq(input string name);
    int ru, t, nfail, ffi, nprobe, nreq, done_c, qi, resp_at, resp_k;
    int req_c[N];
    bit got_done;
    ru = (halt_at >= 1 && halt_at <= RUNC) ? halt_at : RUNC;
    t = RC + ru + 1; nfail = 0; ffi = -1; nprobe = 0;
    for (int i = 0; i < N; i++) begin
      if (!en_a[i]) begin
        req_c[i] = -1;
        t += 1;
      end else begin
        req_c[i] = t;
        nprobe++;
        t += 1 + ((lat_a[i] == 0) ? PT : lat_a[i]);
        if (lat_a[i] == 0 || peek(mem_a[i], addr_a[i]) != exp_a[i]) begin
          nfail++;
          if (ffi < 0) ffi = i;
        end
      end
    end
    done_c = t;

    apply_cfg();
    @(negedge clk);
    start = 1; cpu_halt = 0; probe_valid = 0;
    nreq = 0; qi = 0; resp_at = -1; resp_k = 0; got_done = 0;
    for (int n = 1; n <= done_c + 20 && !got_done; n++) begin
      @(negedge clk);
      start = 0; cpu_halt = 0; probe_valid = 0; probe_data = $urandom;
      if (n == 1) begin
        chk({name, ":busy_c1"}, 32'(busy), 1);
        chk({name, ":cpu_rst_c1"}, 32'(cpu_rst), 1);
      end
      if (n == RC) chk({name, ":cpu_rst_held"}, 32'(cpu_rst), 1);
      if (n == RC + 1) begin
        chk({name, ":cpu_rst_released"}, 32'(cpu_rst), 0);
        start = 1;
      end
      if (n == RC + 2) probe_valid = 1;
      if (halt_at > 0 && n == RC + halt_at) cpu_halt = 1;
      if (probe_req) begin
        nreq++;
        while (qi < N && !en_a[qi]) qi++;
        if (qi >= N) begin
          chk({name, ":req_extra"}, 32'(probe_req), 0);
        end else begin
          chk({name, ":req_cycle"}, n, req_c[qi]);
          chk({name, ":req_addr"}, 32'(probe_addr), 32'(addr_a[qi]));
          chk({name, ":req_kind"}, 32'(probe_is_mem), 32'(mem_a[qi]));
          resp_k  = qi;
          resp_at = (lat_a[qi] == 0) ? -1 : n + lat_a[qi];
          if (garble[qi]) begin
            probe_valid = 1;
            probe_data  = ~peek(mem_a[qi], addr_a[qi]);
          end
          qi++;
        end
      end
      if (n == resp_at) begin
        chk({name, ":addr_stable"}, 32'(probe_addr), 32'(addr_a[resp_k]));
        probe_valid = 1;
        probe_data  = peek(mem_a[resp_k], addr_a[resp_k]);
      end
      if (done) begin
        chk({name, ":done_cycle"}, n, done_c);
        got_done = 1;
      end
    end
    if (!got_done) chk({name, ":done_timeout"}, 32'(done), 1);
    chk({name, ":pass"}, 32'(pass), 32'(nfail == 0));
    chk({name, ":fail_count"}, 32'(fail_count), nfail);
    if (nfail > 0) chk({name, ":first_fail_idx"}, 32'(first_fail_idx), ffi);
    chk({name, ":run_used"}, 32'(run_cycles_used), ru);
    chk({name, ":busy_done"}, 32'(busy), 0);
    chk({name, ":cpu_parked"}, 32'(cpu_rst), 1);
    chk({name, ":probe_count"}, nreq, nprobe);
    @(negedge clk);
    @(negedge clk);
    chk({name, ":done_hold"}, 32'(done), 1);
    chk({name, ":pass_hold"}, 32'(pass), 32'(nfail == 0));
  endtask

  initial begin
    bool_init: begin end
    rst = 1; start = 0; cpu_halt = 0; probe_valid = 0; probe_data = '0;
    chk_en = '0; chk_is_mem = '0; chk_addr = '0; chk_exp = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 1024; i++) dmem[i] = $urandom;
    rf[0] = '0;
    rf[1] = 32'h12345000;
    rf[2] = 32'h12345001;
    dmem[0] = 32'h12345001;

    repeat (3) @(negedge clk);
    chk("rst:cpu_rst", 32'(cpu_rst), 1);
    chk("rst:probe_req", 32'(probe_req), 0);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:pass", 32'(pass), 0);
    chk("rst:fail_count", 32'(fail_count), 0);
    chk("rst:first_fail_idx", 32'(first_fail_idx), 0);
    chk("rst:run_used", 32'(run_cycles_used), 0);
    chk("rst:probe_addr", 32'(probe_addr), 0);
    rst = 0;
    @(negedge clk);

    set_baseline();
    run_seq("baseline");

    set_baseline();
    exp_a[1] = 32'h12345002;
    run_seq("bad_x2");

    set_baseline();
    halt_at = 6;
    run_seq("halt6");

    set_baseline();
    lat_a[0] = 0;
    run_seq("timeout0");

    clear_cfg();
    run_seq("all_off");

    // Reset while entry 0 waits on a silent responder.
    set_baseline();
    lat_a[0] = 0;
    apply_cfg();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 60 && !probe_req; n++) @(negedge clk);
    chk("midrst:req_seen", 32'(probe_req), 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst:cpu_rst", 32'(cpu_rst), 1);
    chk("midrst:busy", 32'(busy), 0);
    chk("midrst:done", 32'(done), 0);
    chk("midrst:probe_req", 32'(probe_req), 0);
    chk("midrst:run_used", 32'(run_cycles_used), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst:idle_cpu_rst", 32'(cpu_rst), 1);
    chk("midrst:idle_busy", 32'(busy), 0);
    chk("midrst:idle_done", 32'(done), 0);

    for (int s = 0; s < 16; s++) begin
      clear_cfg();
      for (int i = 0; i < N; i++) begin
        en_a[i]   = ($urandom_range(0, 3) != 0);
        mem_a[i]  = $urandom_range(0, 1);
        addr_a[i] = ADDR_W'($urandom_range(0, 1023));
        exp_a[i]  = ($urandom_range(0, 1) == 1) ? peek(mem_a[i], addr_a[i]) : $urandom;
        lat_a[i]  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, PT);
        garble[i] = $urandom_range(0, 1);
      end
      halt_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, RUNC + 3) : 0;
      run_seq($sformatf("rand%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_test_sequencer.md
# cpu_test_sequencer

Synthesizable self-check sequencer for the pipelined CPU: holds the core in reset for a programmable time, lets it run for a bounded number of cycles or until it halts, then reads back up to NUM_CHECKS register or data-memory locations through a probe handshake and compares them against expected values. It sits beside `PipelinedCPU` in simulation and FPGA bring-up tops. It replaces hierarchical pokes with a reusable, parametrised pass/fail engine.

## Interface
- `XLEN`, 32, data width of compared values
- `ADDR_W`, 10, probe address width (register index uses low 5 bits)
- `NUM_CHECKS`, 8, check table entries (1..64)
- `RESET_CYCLES`, 2, cycles `cpu_rst` held after start (≥1)
- `RUN_CYCLES`, 15, maximum run cycles before checking (≥1)
- `PROBE_TIMEOUT`, 8, cycles to wait for `probe_valid` before declaring the check failed (≥1)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse; begins a sequence
- `cpu_halt` in 1: CPU halt indication; ends RUN early
- `chk_en` in NUM_CHECKS: per-entry enable
- `chk_is_mem` in NUM_CHECKS: 1 = data memory word, 0 = register
- `chk_addr` in NUM_CHECKS×ADDR_W: probe address per entry
- `chk_exp` in NUM_CHECKS×XLEN: expected value per entry
- `cpu_rst` out 1: reset to CPU
- `probe_req` out 1: one-cycle read request
- `probe_is_mem` out 1, `probe_addr` out ADDR_W: request qualifiers, stable from req until response/timeout
- `probe_valid` in 1, `probe_data` in XLEN: read response
- `busy` out 1, `done` out 1, `pass` out 1
- `fail_count` out $clog2(NUM_CHECKS+1)
- `first_fail_idx` out $clog2(NUM_CHECKS) (valid when fail_count≠0)
- `run_cycles_used` out 16: RUN cycles consumed, saturating at 0xFFFF

## Operation
- States: IDLE, RESET, RUN, CHK_REQ, CHK_WAIT, DONE.
- Reset values: state IDLE, `cpu_rst`=1, `probe_req`=0, `busy`=0, `done`=0, `pass`=0, counters/idx/addr 0.
- IDLE/DONE + `start` → RESET; clears fail_count, first_fail_idx, run_cycles_used, done, pass; `busy`=1. `start` in any other state ignored.
- RESET: `cpu_rst`=1 for exactly RESET_CYCLES cycles → RUN.
- RUN: `cpu_rst`=0; increments run_cycles_used each cycle; leaves after RUN_CYCLES cycles or the cycle `cpu_halt`=1 (halt cycle counted), whichever first → CHK_REQ at index 0.
- CHK_REQ: skips disabled entries (one cycle per skipped index, no probe); enabled entry: drive `probe_req`=1 for one cycle with its addr/kind → CHK_WAIT. Past last index → DONE.
- CHK_WAIT: on `probe_valid`, compare `probe_data`==`chk_exp[i]` (full XLEN); mismatch increments fail_count and, if first failure, latches i. No response within PROBE_TIMEOUT cycles counts as mismatch. Then next index → CHK_REQ.
- `probe_valid` outside CHK_WAIT ignored; `probe_valid` in the same cycle as `probe_req` not accepted (earliest response one cycle after req).
- DONE: `cpu_rst`=1 (CPU parked), `busy`=0, `done`=1, `pass`=(fail_count==0); holds until `start` or `rst`.
- All entries disabled: DONE with pass=1, zero probes.
- `rst` mid-sequence: immediate return to IDLE with reset values; in-flight probe abandoned.

## Timing
- `start` sampled at cycle 0 → `cpu_rst` stays 1 cycles 1..RESET_CYCLES, low from cycle RESET_CYCLES+1.
- Without halt, first `probe_req` at cycle RESET_CYCLES+RUN_CYCLES+1 (+1 per leading disabled entry).
- Per enabled check: 1 req cycle + response latency (1..PROBE_TIMEOUT); timeout entry costs 1+PROBE_TIMEOUT cycles.
- `done`/`pass`/`fail_count` registered, valid the cycle after the final compare.

## Structure
- `cpu_test_pkg`: state enum `seq_state_t`, check-kind constants `CHK_REG`/`CHK_MEM`, shared probe width defaults.
- One sub-module: `cycle_down_counter` (load, decrement, zero flag), reused for RESET, RUN and probe timeout.
- Probe responder (reg file/data memory read mux) lives in the top, not here.

## Test plan
- Baseline program (LUI x1,0x12345; ADDI x2,x1,1; SW x2,0(x0)), RESET_CYCLES=2, RUN_CYCLES=15, checks x1=0x12345000, x2=0x12345001, mem[0]=0x12345001 → done=1, pass=1, fail_count=0, run_cycles_used=15.
- Same, entry 1 expects 0x12345002 → pass=0, fail_count=1, first_fail_idx=1.
- `cpu_halt` pulsed at RUN cycle 6 → run_cycles_used=6, first probe_req next cycle.
- Responder never answers entry 0, PROBE_TIMEOUT=8 → entry 0 fails after 8 wait cycles, entry 1 still probed, fail_count=1.
- chk_en=0 → done 1 cycle after RUN end + NUM_CHECKS skip cycles, pass=1, no probe_req.
- `rst` asserted in CHK_WAIT, `start` pulsed while busy → IDLE, cpu_rst=1, done=0; mid-run start ignored.
